// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle radix-4 Booth multiplier with a start/done handshake.
// Each RUN cycle retires one Booth digit, which is two multiplier bits.
//
// Parameters
//   WIDTH        operand width. It must be even and at least 4. The product is 2*WIDTH bits.
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   start        request to multiply. It is sampled only in IDLE or DONE.
//   signed_mode  1: operands are two's complement. 0: operands are unsigned.
//   M            multiplicand, captured on the accepting edge
//   Q            multiplier, captured on the accepting edge
//   busy         high while an operation runs
//   done         one-cycle pulse on the edge where P becomes valid
//   P            product. It holds its value until the next result replaces it.
// Configuration
//   BOOTH_EARLY_TERM_EN  when defined, the operation finishes as soon as every
//                        remaining Booth digit is zero, so latency depends on the data.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned EW = WIDTH + 2;       // extended operand width
  localparam int unsigned AW = 2 * WIDTH + 2;   // accumulator width
  localparam int unsigned N  = WIDTH / 2 + 1;   // Booth digits per operation
  localparam int unsigned SW = $clog2(N + 1);   // step counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [EW-1:0]   r_m;
  logic [EW-1:0]   r_q;
  logic            r_guard;
  logic [AW-1:0]   r_acc;
  logic [SW-1:0]   r_step;

  logic [EW-1:0]   w_m_ext;
  logic [EW-1:0]   w_q_ext;
  logic [EW-1:0]   w_pp;
  logic [AW-1:0]   w_addend;
  logic [AW-1:0]   w_acc_nxt;
  logic            w_last;

  // The operands are extended once at accept. The extension is where signed_mode takes effect.
  assign w_m_ext = signed_mode ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
  assign w_q_ext = signed_mode ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};

  // Booth digit decode. The +-2M term is formed at EW bits, so a most-negative M cannot overflow.
  always_comb begin
    w_pp = '0;
    case ({r_q[1:0], r_guard})
      3'b001, 3'b010: w_pp = r_m;
      3'b011:         w_pp = {r_m[EW-2:0], 1'b0};
      3'b100:         w_pp = EW'(~{r_m[EW-2:0], 1'b0} + 1'b1);
      3'b101, 3'b110: w_pp = EW'(~r_m + 1'b1);
      default:        w_pp = '0;
    endcase
  end

  // The partial product is sign-extended and then weighted by 4^step.
  assign w_addend  = {{WIDTH{w_pp[EW-1]}}, w_pp} << {r_step, 1'b0};
  assign w_acc_nxt = r_acc + w_addend;

`ifdef BOOTH_EARLY_TERM_EN
  // After the shift, the remaining multiplier bits and the new guard are r_q[EW-1:1].
  // When those bits are all equal, every later digit is zero.
  logic w_rest_eq;
  assign w_rest_eq = (&r_q[EW-1:1]) | ~(|r_q[EW-1:1]);
  assign w_last    = (r_step == SW'(N - 1)) | w_rest_eq;
`else
  assign w_last    = (r_step == SW'(N - 1));
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_q     <= '0;
      r_guard <= 1'b0;
      r_acc   <= '0;
      r_step  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      P       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_m     <= w_m_ext;
            r_q     <= w_q_ext;
            r_guard <= 1'b0;
            r_acc   <= '0;
            r_step  <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_q     <= {{2{r_q[EW-1]}}, r_q[EW-1:2]};
          r_guard <= r_q[1];
          r_step  <= SW'(r_step + 1'b1);
          if (w_last) begin
            P       <= w_acc_nxt[2*WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Testbench for booth_mul_seq at WIDTH=32. It uses directed corner operands,
// randomized operands, a back-to-back start, start while busy, and reset mid-run.
module tb_booth_mul_seq;

  localparam int unsigned W = 32;
  localparam int unsigned N = W / 2 + 1;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   M;
  logic [W-1:0]   Q;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .M(M), .Q(Q), .busy(busy), .done(done), .P(P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference product, computed from plain 64-bit arithmetic
  function automatic logic [63:0] ref_p(input logic [31:0] m, input logic [31:0] q,
                                        input logic sm);
    logic signed [63:0] sa, sb;
    if (sm) begin
      sa = $signed({{32{m[31]}}, m});
      sb = $signed({{32{q[31]}}, q});
      return 64'(sa * sb);
    end
    return {32'b0, m} * {32'b0, q};
  endfunction

  // Expected latency. With early termination, the operation ends after the first k
  // digits once extended multiplier bits [33:2k-1] are all equal.
  function automatic int ref_lat(input logic [31:0] q, input logic sm);
    logic [33:0] x;
    int k_early;
    bit same;
    x = sm ? {{2{q[31]}}, q} : {2'b00, q};
    k_early = N;
    for (int k = N; k >= 1; k--) begin
      same = 1'b1;
      for (int j = 2 * k - 1; j <= 33; j++) if (x[j] != x[33]) same = 1'b0;
      if (same) k_early = k;
    end
    return EARLY ? k_early : N;
  endfunction

  // Drive start from the current time until the next rising edge, then scramble the operands.
  task automatic issue(input logic [31:0] m, input logic [31:0] q, input logic sm);
    start = 1'b1; M = m; Q = q; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; M = $urandom; Q = $urandom; signed_mode = 1'($urandom);
  endtask

  // Wait for done and count the cycles. Optionally pulse start with other operands at cycle pulse_at.
  task automatic wait_result(input string tag, input logic [63:0] exp_p, input int exp_lat,
                             input int pulse_at);
    int cyc;
    int busy_cnt;
    bit got;
    cyc = 0; busy_cnt = (busy === 1'b1) ? 1 : 0; got = 1'b0;
    while (!got && cyc < 60) begin
      if (pulse_at != 0 && cyc == pulse_at) begin
        start = 1'b1; M = $urandom; Q = $urandom; signed_mode = 1'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busycyc"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, "_P"}, P, exp_p);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                       input logic sm, input logic [63:0] exp_p);
    @(negedge clk);
    issue(m, q, sm);
    wait_result(tag, exp_p, ref_lat(q, sm), 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] rm, rq;
    logic        rs;
    int          done_seen;

    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; M = '0; Q = '0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_P", P, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases with literal expected products
    do_op("u7x3",     32'd7,          32'd3,          1'b0, 64'h15);
    do_op("s_m5x3",   32'hFFFFFFFB,   32'h00000003,   1'b1, 64'hFFFFFFFF_FFFFFFF1);
    do_op("u_ffxff",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE_00000001);
    do_op("s_ffxff",  32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h1);
    do_op("s_minmin", 32'h80000000,   32'h80000000,   1'b1, 64'h40000000_00000000);
    do_op("s_minmax", 32'h80000000,   32'h7FFFFFFF,   1'b1, 64'hC0000000_80000000);
    do_op("u_zero",   32'h12345678,   32'h0,          1'b0, 64'h0);
    do_op("u_minmin", 32'h80000000,   32'h80000000,   1'b0, 64'h40000000_00000000);

    // Randomized operands checked against the reference product
    for (int i = 0; i < 24; i++) begin
      rm = $urandom; rq = $urandom; rs = 1'($urandom);
      if (i % 4 == 1) rq = $urandom_range(0, 15);
      if (i % 4 == 2) rq = ~32'($urandom_range(0, 15));
      do_op($sformatf("rand%0d", i), rm, rq, rs, ref_p(rm, rq, rs));
    end

    // A start during RUN is ignored. A start in the DONE cycle is accepted back-to-back.
    @(negedge clk);
    issue(32'd1000, 32'd77777, 1'b0);
    wait_result("ign", 64'd77777000, ref_lat(32'd77777, 1'b0), 5);
    issue(32'hFFFF_FF00, 32'd12345, 1'b1);
    wait_result("b2b", ref_p(32'hFFFF_FF00, 32'd12345, 1'b1), ref_lat(32'd12345, 1'b1), 0);
    @(posedge clk); #1;
    chk("b2b_done_pulse", 64'(done), 64'd0);

    // Reset mid-run aborts at once
    @(negedge clk);
    issue(32'hDEADBEEF, 32'hCAFEBABE, 1'b0);
    for (int c = 0; c < 7; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_run_busy", 64'(busy), 64'd0);
    chk("rst_run_done", 64'(done), 64'd0);
    chk("rst_run_P", P, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    chk("rst_no_done", 64'(done_seen), 64'd0);
    do_op("after_rst", 32'hDEADBEEF, 32'hCAFEBABE, 1'b0, ref_p(32'hDEADBEEF, 32'hCAFEBABE, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
